// File: rtl/ext_int_ctrl_mc_pkg.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl_mc_pkg
// Shared definitions for the multi-channel external interrupt controller:
//   - IO address table: register offsets inside the EIC block slot
//   - request FSM state enum (IDLE / REQ / GAP)
//   - lowestSetIndex(): fixed-priority encoder, lowest index wins
// No ports; imported by ext_int_ctrl_mc and int_sync_edge.
// ---------------------------------------------------------------------------
package ext_int_ctrl_mc_pkg;

    // Register offsets on Sys_RegAddress
    localparam logic [3:0] EIC_ENABLE   = 4'h0;
    localparam logic [3:0] EIC_MODE     = 4'h1;
    localparam logic [3:0] EIC_POLARITY = 4'h2;
    localparam logic [3:0] EIC_PENDING  = 4'h3;
    localparam logic [3:0] EIC_STATUS   = 4'h4;
    localparam logic [3:0] EIC_RAW      = 4'h5;

    // Bit of STATUS that reports an outstanding request
    localparam int STATUS_INSERVICE_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } eicState_t;

    // Scans downwards so the last hit, i.e. the lowest set bit, is kept.
    // Callers zero-pad narrower request vectors to 32 bits.
    function automatic logic [4:0] lowestSetIndex(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ext_int_ctrl_mc_int_sync_edge.sv
// ---------------------------------------------------------------------------
// int_sync_edge
// One interrupt channel front end: a SYNC_STAGES-deep synchroniser for an
// asynchronous source, polarity correction, and a history flop for edges.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   async_i     raw asynchronous interrupt source
//   polarity_i  1 = active high / rising, 0 = active low / falling
//   level_o     synchronised, polarity-corrected active level
//   rise_o      one-cycle pulse when level_o goes 0->1
// ---------------------------------------------------------------------------
module int_sync_edge
    import ext_int_ctrl_mc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    input  logic polarity_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   history_q;

    // Plain shift chain; only the last stage is used downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Polarity applies after synchronisation, so a polarity write takes
    // effect immediately and may itself produce a rise.
    assign level_o = syncChain_q[SYNC_STAGES-1] ~^ polarity_i;

    // Remembers the previous active level for rise detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            history_q <= 1'b0;
        end else begin
            history_q <= level_o;
        end
    end

    assign rise_o = level_o & ~history_q;

endmodule

// File: rtl/ext_int_ctrl_mc.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl_mc
// Multi-channel external interrupt controller. Synchronises NUM_CH sources,
// applies per-channel enable / edge-level mode / polarity, arbitrates with
// fixed priority (lowest index wins) and presents one vectored request with
// an acknowledge handshake. Registers sit behind the IO block-select bus.
// Ports:
//   Sys_Clock, Sys_Reset      clock, asynchronous active-low reset
//   IntSrc[NUM_CH]            raw asynchronous interrupt sources
//   Sys_BlockSelect/RegAddress/WrEn/RdEn/WrData   register access
//   Sys_RdData                combinational read data (0 when not reading)
//   EIC_IntReq, EIC_IntId     request and id of the requested channel
//   EIC_IntAck                one-cycle acknowledge from the processor
// ---------------------------------------------------------------------------
module ext_int_ctrl_mc
    import ext_int_ctrl_mc_pkg::*;
#(
    parameter int                NUM_CH      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [NUM_CH-1:0] RESET_MODE  = '0
) (
    input  logic              Sys_Clock,
    input  logic              Sys_Reset,
    input  logic [NUM_CH-1:0] IntSrc,
    input  logic              Sys_BlockSelect,
    input  logic [3:0]        Sys_RegAddress,
    input  logic              Sys_WrEn,
    input  logic              Sys_RdEn,
    input  logic [31:0]       Sys_WrData,
    output logic [31:0]       Sys_RdData,
    output logic              EIC_IntReq,
    output logic [ID_W-1:0]   EIC_IntId,
    input  logic              EIC_IntAck
);

    logic [NUM_CH-1:0] enable_q, mode_q, polarity_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] activeLevel, risePulse;
    logic [NUM_CH-1:0] wrBits, w1cMask, ackClear, modeToEdge;
    eicState_t         state_q, state_d;
    logic [ID_W-1:0]   intId_q, intId_d;
    logic              regWrite;
    logic [31:0]       reqVec;
    logic [4:0]        winner;
    logic              unusedBits;

    assign regWrite   = Sys_BlockSelect & Sys_WrEn;
    assign wrBits     = Sys_WrData[NUM_CH-1:0];
    assign unusedBits = ^{Sys_WrData, winner};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gSync
        int_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) uSync (
            .clk_i     (Sys_Clock),
            .rst_ni    (Sys_Reset),
            .async_i   (IntSrc[ch]),
            .polarity_i(polarity_q[ch]),
            .level_o   (activeLevel[ch]),
            .rise_o    (risePulse[ch])
        );
    end

    // Software-visible configuration registers.
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            enable_q   <= '0;
            mode_q     <= RESET_MODE;
            polarity_q <= '1;
        end else if (regWrite) begin
            case (Sys_RegAddress)
                EIC_ENABLE:   enable_q   <= wrBits;
                EIC_MODE:     mode_q     <= wrBits;
                EIC_POLARITY: polarity_q <= wrBits;
                default:      ;
            endcase
        end
    end

    // Pending: edge channels latch rises (a rise beats any same-cycle clear),
    // level channels follow the live level, and a channel just switched to
    // edge mode starts clean.
    always_comb begin
        w1cMask    = '0;
        ackClear   = '0;
        modeToEdge = '0;
        if (regWrite && (Sys_RegAddress == EIC_PENDING)) begin
            w1cMask = wrBits;
        end
        if (regWrite && (Sys_RegAddress == EIC_MODE)) begin
            modeToEdge = wrBits & ~mode_q;
        end
        if ((state_q == REQ) && EIC_IntAck) begin
            ackClear[intId_q] = mode_q[intId_q];
        end
        pending_d = ((mode_q & (risePulse | (pending_q & ~(w1cMask | ackClear))))
                    | (~mode_q & activeLevel)) & ~modeToEdge;
    end

    // Request FSM: the id is captured on entry to REQ and held until ack, so
    // later disables or W1C cannot retract or change an issued request.
    always_comb begin
        reqVec               = '0;
        reqVec[NUM_CH-1:0]   = pending_q & enable_q;
        winner               = lowestSetIndex(reqVec);
        state_d              = state_q;
        intId_d              = intId_q;
        case (state_q)
            IDLE: begin
                if (|reqVec) begin
                    state_d = REQ;
                    intId_d = winner[ID_W-1:0];
                end
            end
            REQ: begin
                if (EIC_IntAck) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured id and pending flags.
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            state_q   <= IDLE;
            intId_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            intId_q   <= intId_d;
            pending_q <= pending_d;
        end
    end

    assign EIC_IntReq = (state_q == REQ);
    assign EIC_IntId  = intId_q;

    // Read mux; unmapped offsets and bits above NUM_CH read as zero.
    always_comb begin
        Sys_RdData = '0;
        if (Sys_BlockSelect && Sys_RdEn) begin
            case (Sys_RegAddress)
                EIC_ENABLE:   Sys_RdData[NUM_CH-1:0] = enable_q;
                EIC_MODE:     Sys_RdData[NUM_CH-1:0] = mode_q;
                EIC_POLARITY: Sys_RdData[NUM_CH-1:0] = polarity_q;
                EIC_PENDING:  Sys_RdData[NUM_CH-1:0] = pending_q;
                EIC_STATUS: begin
                    Sys_RdData[STATUS_INSERVICE_BIT] = (state_q == REQ);
                    Sys_RdData[ID_W-1:0]             = intId_q;
                end
                EIC_RAW:      Sys_RdData[NUM_CH-1:0] = activeLevel;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_ext_int_ctrl_mc
// Self-checking bench for ext_int_ctrl_mc (NUM_CH=8, SYNC_STAGES=2).
// A vector table covers the basic edge-channel flow, hand sequences cover
// priority, level, polarity/mask, collisions and asynchronous reset, and a
// random phase compares the DUT against a behavioural model every cycle.
// ---------------------------------------------------------------------------
module tb_ext_int_ctrl_mc;

    localparam int NUM_CH      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = 3;

    logic              Sys_Clock = 1'b0;
    logic              Sys_Reset;
    logic [NUM_CH-1:0] IntSrc;
    logic              Sys_BlockSelect;
    logic [3:0]        Sys_RegAddress;
    logic              Sys_WrEn;
    logic              Sys_RdEn;
    logic [31:0]       Sys_WrData;
    logic [31:0]       Sys_RdData;
    logic              EIC_IntReq;
    logic [ID_W-1:0]   EIC_IntId;
    logic              EIC_IntAck;

    int assertCount = 0;
    int failCount   = 0;

    ext_int_ctrl_mc #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(SYNC_STAGES),
        .ID_W       (ID_W),
        .RESET_MODE ('0)
    ) dut (
        .Sys_Clock      (Sys_Clock),
        .Sys_Reset      (Sys_Reset),
        .IntSrc         (IntSrc),
        .Sys_BlockSelect(Sys_BlockSelect),
        .Sys_RegAddress (Sys_RegAddress),
        .Sys_WrEn       (Sys_WrEn),
        .Sys_RdEn       (Sys_RdEn),
        .Sys_WrData     (Sys_WrData),
        .Sys_RdData     (Sys_RdData),
        .EIC_IntReq     (EIC_IntReq),
        .EIC_IntId      (EIC_IntId),
        .EIC_IntAck     (EIC_IntAck)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    // Behavioural model state: a plain delay line of sampled sources, the
    // previous active level, registers, and a busy/gap view of the handshake.
    logic [NUM_CH-1:0] mDelay [SYNC_STAGES];
    logic [NUM_CH-1:0] mPrevActive, mPend, mEn, mMode, mPol;
    bit                mBusy, mGap;
    int                mCurId;

    typedef struct {
        logic [3:0]        addr;
        logic              wr;
        logic [31:0]       wdata;
        logic              rd;
        logic [NUM_CH-1:0] src;
        logic              ack;
        logic              expReq;
        logic [ID_W-1:0]   expId;
        logic [31:0]       expRd;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic wr, input logic [31:0] wdata,
                                 input logic rd, input logic ack);
        Sys_BlockSelect = 1'b1;
        Sys_RegAddress  = addr;
        Sys_WrEn        = wr;
        Sys_WrData      = wdata;
        Sys_RdEn        = rd;
        EIC_IntAck      = ack;
    endtask

    task automatic idleBus();
        applyStimulus(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Inputs change on the falling edge; outputs are sampled there as well.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge Sys_Clock);
            @(negedge Sys_Clock);
        end
    endtask

    task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
        applyStimulus(addr, 1'b1, data, 1'b0, 1'b0);
        cycle();
        idleBus();
    endtask

    task automatic readCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
        applyStimulus(addr, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        checkOutput(name, Sys_RdData, expected);
        idleBus();
    endtask

    task automatic ackPulse();
        applyStimulus(4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle();
        idleBus();
    endtask

    // Bounded wait for IntReq; a timeout shows up as a wrong latency/req.
    task automatic waitReq(input string name, input int maxCycles, input int expCycles, input int expId);
        int count = 0;
        while (!EIC_IntReq && count < maxCycles) begin
            cycle();
            count++;
        end
        checkOutput({name, " req"}, 32'(EIC_IntReq), 32'd1);
        checkOutput({name, " latency"}, count, expCycles);
        checkOutput({name, " id"}, 32'(EIC_IntId), expId);
    endtask

    task automatic doReset();
        idleBus();
        IntSrc    = '0;
        Sys_Reset = 1'b0;
        cycle(2);
        Sys_Reset = 1'b1;
        cycle();
    endtask

    task automatic modelReset();
        for (int k = 0; k < SYNC_STAGES; k++) mDelay[k] = '0;
        mPrevActive = '0;
        mPend       = '0;
        mEn         = '0;
        mMode       = '0;
        mPol        = '1;
        mBusy       = 0;
        mGap        = 0;
        mCurId      = 0;
    endtask

    function automatic logic [NUM_CH-1:0] modelActive();
        return mDelay[SYNC_STAGES-1] ^ ~mPol;
    endfunction

    function automatic logic [31:0] modelRead();
        logic [31:0] r;
        r = '0;
        if (Sys_BlockSelect && Sys_RdEn) begin
            case (Sys_RegAddress)
                4'h0: r = 32'(mEn);
                4'h1: r = 32'(mMode);
                4'h2: r = 32'(mPol);
                4'h3: r = 32'(mPend);
                4'h4: r = {mBusy, 28'h0, 3'(mCurId)};
                4'h5: r = 32'(modelActive());
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Advances the model across one rising edge using the current inputs.
    task automatic modelStep();
        logic [NUM_CH-1:0] active, rise, w1c, ackClr, newMode, newPend, req;
        bit wr;
        active  = modelActive();
        rise    = active & ~mPrevActive;
        wr      = Sys_BlockSelect && Sys_WrEn;
        w1c     = (wr && Sys_RegAddress == 4'h3) ? Sys_WrData[NUM_CH-1:0] : '0;
        newMode = (wr && Sys_RegAddress == 4'h1) ? Sys_WrData[NUM_CH-1:0] : mMode;
        ackClr  = '0;
        if (mBusy && EIC_IntAck && mMode[mCurId]) ackClr[mCurId] = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mMode[i] && newMode[i]) newPend[i] = 1'b0;
            else if (mMode[i])           newPend[i] = rise[i] | (mPend[i] & ~(w1c[i] | ackClr[i]));
            else                         newPend[i] = active[i];
        end
        req = mPend & mEn;
        if (mBusy) begin
            if (EIC_IntAck) begin
                mBusy = 0;
                mGap  = 1;
            end
        end else if (mGap) begin
            mGap = 0;
        end else if (req != 0) begin
            mBusy = 1;
            for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) mCurId = i;
        end
        if (wr && Sys_RegAddress == 4'h0) mEn  = Sys_WrData[NUM_CH-1:0];
        if (wr && Sys_RegAddress == 4'h2) mPol = Sys_WrData[NUM_CH-1:0];
        mMode       = newMode;
        mPend       = newPend;
        mPrevActive = active;
        for (int k = SYNC_STAGES - 1; k > 0; k--) mDelay[k] = mDelay[k-1];
        mDelay[0] = IntSrc;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Edge channel 3: write ENABLE/MODE, pulse the source, ack.
        vecs[0]  = '{4'h0, 1'b1, 32'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[1]  = '{4'h1, 1'b1, 32'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[2]  = '{4'h0, 1'b0, 32'h00, 1'b0, 8'h08, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[3]  = '{4'h0, 1'b0, 32'h00, 1'b0, 8'h08, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[4]  = '{4'h5, 1'b0, 32'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 32'h08};
        vecs[5]  = '{4'h3, 1'b0, 32'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 32'h08};
        vecs[6]  = '{4'h4, 1'b0, 32'h00, 1'b1, 8'h00, 1'b0, 1'b1, 3'd3, 32'h8000_0003};
        vecs[7]  = '{4'h3, 1'b0, 32'h00, 1'b1, 8'h00, 1'b1, 1'b1, 3'd3, 32'h08};
        vecs[8]  = '{4'h3, 1'b0, 32'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[9]  = '{4'h0, 1'b0, 32'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h0};
        vecs[10] = '{4'h0, 1'b0, 32'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 32'h0};

        Sys_Reset = 1'b0;
        IntSrc    = '0;
        idleBus();
        @(negedge Sys_Clock);
        doReset();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].ack);
            IntSrc = vecs[i].src;
            #1;
            checkOutput($sformatf("edge row%0d req", i), 32'(EIC_IntReq), 32'(vecs[i].expReq));
            if (vecs[i].expReq)
                checkOutput($sformatf("edge row%0d id", i), 32'(EIC_IntId), 32'(vecs[i].expId));
            checkOutput($sformatf("edge row%0d rddata", i), Sys_RdData, vecs[i].expRd);
            cycle();
        end
        idleBus();

        // Priority: channels 5 and 2 rise together, then async reset mid-REQ.
        doReset();
        regWrite(4'h0, 32'hFF);
        regWrite(4'h1, 32'hFF);
        IntSrc = 8'h24;
        waitReq("priority first", 10, 4, 2);
        ackPulse();
        readCheck("priority pending after ack", 4'h3, 32'h20);
        waitReq("priority second", 10, 2, 5);
        #2;
        Sys_Reset = 1'b0;
        #1;
        checkOutput("async reset drops IntReq", 32'(EIC_IntReq), 32'd0);
        readCheck("reset ENABLE", 4'h0, 32'h0);
        readCheck("reset MODE", 4'h1, 32'h0);
        readCheck("reset POLARITY", 4'h2, 32'hFF);
        readCheck("reset PENDING", 4'h3, 32'h0);
        readCheck("reset STATUS", 4'h4, 32'h0);
        readCheck("reset RAW", 4'h5, 32'h0);
        applyStimulus(4'h2, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("rddata gated without RdEn", Sys_RdData, 32'h0);
        @(negedge Sys_Clock);
        Sys_Reset = 1'b1;
        IntSrc    = '0;
        idleBus();
        cycle();

        // Level channel 1 held high: re-request after ack, then release.
        doReset();
        regWrite(4'h0, 32'h02);
        IntSrc = 8'h02;
        waitReq("level first", 10, 4, 1);
        ackPulse();
        waitReq("level rerequest", 10, 2, 1);
        regWrite(4'h3, 32'h02);
        readCheck("level ignores W1C", 4'h3, 32'h02);
        IntSrc = 8'h00;
        cycle(3);
        readCheck("level pending follows release", 4'h3, 32'h00);
        ackPulse();
        begin
            logic sawReq = 1'b0;
            for (int k = 0; k < 6; k++) begin
                cycle();
                sawReq |= EIC_IntReq;
            end
            checkOutput("level no request after release", 32'(sawReq), 32'd0);
        end

        // Polarity and mask on channel 4 (level mode, disabled).
        doReset();
        regWrite(4'h2, 32'hEF);
        readCheck("polarity RAW low source", 4'h5, 32'h10);
        cycle(2);
        readCheck("polarity pending masked", 4'h3, 32'h10);
        IntSrc = 8'h10;
        cycle(2);
        readCheck("polarity RAW high source", 4'h5, 32'h00);
        IntSrc = 8'h00;
        cycle(3);
        readCheck("polarity RAW low again", 4'h5, 32'h10);
        checkOutput("masked channel no req", 32'(EIC_IntReq), 32'd0);
        regWrite(4'h0, 32'h10);
        waitReq("enable raises request", 5, 1, 4);

        // Collisions on edge channel 6.
        doReset();
        regWrite(4'h1, 32'h40);
        IntSrc = 8'h40;
        cycle(3);
        readCheck("collision edge pending", 4'h3, 32'h40);
        regWrite(4'h3, 32'h40);
        readCheck("collision plain W1C", 4'h3, 32'h00);
        IntSrc = 8'h00;
        cycle(3);
        IntSrc = 8'h40;
        cycle(2);
        regWrite(4'h3, 32'h40);
        readCheck("collision set beats W1C", 4'h3, 32'h40);
        regWrite(4'h0, 32'h40);
        waitReq("collision request", 5, 1, 6);
        IntSrc = 8'h00;
        cycle(3);
        IntSrc = 8'h40;
        cycle(2);
        ackPulse();
        readCheck("ack with edge keeps pending", 4'h3, 32'h40);
        waitReq("ack with edge rerequest", 10, 2, 6);
        ackPulse();
        readCheck("ack clears edge pending", 4'h3, 32'h00);
        cycle(4);
        checkOutput("no request after final ack", 32'(EIC_IntReq), 32'd0);

        // Random traffic against the behavioural model.
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            IntSrc         ^= 8'($urandom & $urandom & $urandom);
            Sys_BlockSelect = ($urandom_range(0, 7) != 0);
            Sys_RegAddress  = 4'($urandom_range(0, 7));
            Sys_WrEn        = ($urandom_range(0, 7) == 0);
            Sys_WrData      = $urandom;
            Sys_RdEn        = 1'($urandom_range(0, 1));
            EIC_IntAck      = ($urandom_range(0, 3) == 0);
            #1;
            checkOutput($sformatf("rand c%0d req", cyc), 32'(EIC_IntReq), 32'(mBusy));
            if (mBusy)
                checkOutput($sformatf("rand c%0d id", cyc), 32'(EIC_IntId), mCurId);
            checkOutput($sformatf("rand c%0d rddata", cyc), Sys_RdData, modelRead());
            modelStep();
            cycle();
        end
        idleBus();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
